io_bus_ctrl: RTL

IO_BUS_CTRL -- requirements
Module: io_bus_ctrl

---
 rtl/io_bus_ctrl_pkg.sv | 32 +++
 rtl/io_addr_decode.sv | 40 ++++
 rtl/io_bus_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/io_bus_ctrl_pkg.sv
// io_bus_ctrl_pkg -- shared definitions for the CPU IO bus controller.
//   state_e       : controller FSM states (IDLE, ACCESS, DONE)
//   DEV_*         : device indices, i.e. bit positions in the one-hot dev_sel
//   PAGE_*        : io_addr[9:4] values that select each device
//   IO_BASE       : upper 22 address bits of the IO window (all ones)
//   dev_onehot()  : device index -> one-hot select
package io_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam int unsigned NUM_DEV    = 4;
  localparam int unsigned DEV_LED    = 0;
  localparam int unsigned DEV_SWITCH = 1;
  localparam int unsigned DEV_SEG7   = 2;
  localparam int unsigned DEV_TIMER  = 3;

  localparam logic [5:0] PAGE_LED    = 6'h00;
  localparam logic [5:0] PAGE_SWITCH = 6'h01;
  localparam logic [5:0] PAGE_SEG7   = 6'h02;
  localparam logic [5:0] PAGE_TIMER  = 6'h03;

  localparam logic [21:0] IO_BASE = 22'h3F_FFFF;

  function automatic logic [NUM_DEV-1:0] dev_onehot(input int unsigned idx);
    return NUM_DEV'(1 << idx);
  endfunction

endpackage

// File: rtl/io_addr_decode.sv
// io_addr_decode -- combinational IO page decoder.
//   page_i   in  6  io_addr[9:4]
//   sel_o    out 4  one-hot device select (all zero when unmapped)
//   mapped_o out 1  page belongs to a device
module io_addr_decode
  import io_bus_ctrl_pkg::*;
(
  input  logic [5:0] page_i,
  output logic [3:0] sel_o,
  output logic       mapped_o
);

  always_comb begin
    sel_o    = '0;
    mapped_o = 1'b0;
    case (page_i)
      PAGE_LED: begin
        sel_o    = dev_onehot(DEV_LED);
        mapped_o = 1'b1;
      end
      PAGE_SWITCH: begin
        sel_o    = dev_onehot(DEV_SWITCH);
        mapped_o = 1'b1;
      end
      PAGE_SEG7: begin
        sel_o    = dev_onehot(DEV_SEG7);
        mapped_o = 1'b1;
      end
      PAGE_TIMER: begin
        sel_o    = dev_onehot(DEV_TIMER);
        mapped_o = 1'b1;
      end
      default: begin
        sel_o    = '0;
        mapped_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl -- bridges CPU IO load/store requests onto a simple
// request/acknowledge device bus, stalling the pipeline until done.
//   clock, rst_n         clock, async active-low reset
//   io_read/io_write     CPU request (held while stall=1); both set = write
//   io_addr, io_wdata    CPU address [9:0] and store data
//   stall                (io_read|io_write) & (state != DONE)
//   io_rdata             load data, valid in DONE, held otherwise
//   dev_sel/req/we/reg/wdata  device request bundle, registered
//   dev_ack, dev_rdata   device response, only honoured in ACCESS
//   err_unmapped/timeout sticky error flags
//   dbg_state_o          current FSM state, for observation
//
// Device handshake: dev_req rises on entry to ACCESS with dev_sel, dev_we,
// dev_reg and dev_wdata already stable, and all of them stay constant until
// the cycle in which dev_ack=1 is seen (or the wait counter expires); the
// transfer completes on that edge and dev_req drops in DONE.
module io_bus_ctrl
  import io_bus_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        io_read,
  input  logic        io_write,
  input  logic [9:0]  io_addr,
  input  logic [31:0] io_wdata,
  output logic        stall,
  output logic [31:0] io_rdata,
  output logic [3:0]  dev_sel,
  output logic        dev_req,
  output logic        dev_we,
  output logic [3:0]  dev_reg,
  output logic [31:0] dev_wdata,
  input  logic        dev_ack,
  input  logic [31:0] dev_rdata,
  output logic        err_unmapped,
  output logic        err_timeout,
  output state_e      dbg_state_o
);

  // Counter value at which the current ACCESS cycle is the last one allowed.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

  state_e      state_q;
  logic [3:0]  dev_sel_q;
  logic        dev_req_q;
  logic        dev_we_q;
  logic [3:0]  dev_reg_q;
  logic [31:0] dev_wdata_q;
  logic [31:0] io_rdata_q;
  logic [7:0]  wait_q;
  logic        err_unmapped_q;
  logic        err_timeout_q;

  logic [3:0]  dec_sel;
  logic        dec_mapped;
  logic        io_req;

  io_addr_decode u_decode (
    .page_i   (io_addr[9:4]),
    .sel_o    (dec_sel),
    .mapped_o (dec_mapped)
  );

  assign io_req = io_read | io_write;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      dev_sel_q      <= '0;
      dev_req_q      <= 1'b0;
      dev_we_q       <= 1'b0;
      dev_reg_q      <= '0;
      dev_wdata_q    <= '0;
      io_rdata_q     <= '0;
      wait_q         <= '0;
      err_unmapped_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (io_req) begin
            dev_sel_q   <= dec_sel;
            // A simultaneous read and write is handled as a write.
            dev_we_q    <= io_write;
            dev_reg_q   <= io_addr[3:0];
            dev_wdata_q <= io_wdata;
            if (dec_mapped) begin
              state_q   <= ST_ACCESS;
              dev_req_q <= 1'b1;
              wait_q    <= '0;
            end else begin
              state_q        <= ST_DONE;
              io_rdata_q     <= '0;
              err_unmapped_q <= 1'b1;
            end
          end
        end
        // The CPU request is not looked at here: once started, an access
        // runs to completion even if the request is dropped.
        ST_ACCESS: begin
          if (dev_ack) begin
            state_q    <= ST_DONE;
            dev_req_q  <= 1'b0;
            io_rdata_q <= dev_we_q ? 32'd0 : dev_rdata;
          end else begin
            wait_q <= wait_q + 8'd1;
            if (wait_q == TIMEOUT_LAST) begin
              state_q       <= ST_DONE;
              dev_req_q     <= 1'b0;
              io_rdata_q    <= '0;
              err_timeout_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q   <= ST_IDLE;
          dev_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign stall        = io_req & (state_q != ST_DONE);
  assign io_rdata     = io_rdata_q;
  assign dev_sel      = dev_sel_q;
  assign dev_req      = dev_req_q;
  assign dev_we       = dev_we_q;
  assign dev_reg      = dev_reg_q;
  assign dev_wdata    = dev_wdata_q;
  assign err_unmapped = err_unmapped_q;
  assign err_timeout  = err_timeout_q;
  assign dbg_state_o  = state_q;

endmodule
